// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding and the default widths / timeout length.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int TMO_CYC_DEF = 15;

  // Width of the optional retired-instruction counter
  localparam int PERF_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_ISSUE = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

endpackage

// File: rtl/fetch_ctrl_tmo.sv
// fetch_tmo_cnt: counts consecutive cycles in which enable is high and
// flags the cycle that completes TMO_CYC of them. clear has priority.
module fetch_tmo_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // The TMO_CYC-th waiting cycle is the one where cnt already holds TMO_CYC-1
  assign expired = enable && (cnt == LAST);

  // Count waiting cycles; hold at the terminal value once expired
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences instruction fetches from memory and hands each word
// to an executor, steering the PC by increment or branch load on retirement.
// Optional feature: define FETCH_CTRL_PERF_EN to add the perf_retired
// saturating count of retired instructions.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  output logic              pc_jmp,
  output logic [ADDR_W-1:0] pc_addrin,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic              busy,
  output logic              err
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_retired
`endif
);

  state_t state;
  state_t state_nxt;
  logic   stop_pend;
  logic   tmo_expired;
  logic   in_fetch;
  logic   in_issue;
  logic   fetch_done;
  logic   handshake;

  assign in_fetch   = (state == ST_FETCH);
  assign in_issue   = (state == ST_ISSUE);
  assign fetch_done = in_fetch && mem_ack;
  assign handshake  = in_issue && instr_ready;

  // Timeout restarts whenever FETCH is left or a word arrives
  fetch_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_fetch || mem_ack),
    .enable  (in_fetch && !mem_ack),
    .expired (tmo_expired)
  );

  // Next-state selection; a stop seen on the handshake cycle halts at once
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && !stop) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack)          state_nxt = ST_ISSUE;
        else if (tmo_expired) state_nxt = ST_ERR;
      end
      ST_ISSUE: begin
        if (handshake) state_nxt = (stop_pend || stop) ? ST_IDLE : ST_FETCH;
      end
      ST_ERR: begin
        if (start && !stop) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Halt request remembered until the sequencer is back in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      stop_pend <= 1'b0;
    else if (state_nxt == ST_IDLE) stop_pend <= 1'b0;
    else if (busy && stop)         stop_pend <= 1'b1;
  end

  // Sticky timeout flag, cleared only by a restart out of ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          err <= 1'b0;
    else if (in_fetch && state_nxt == ST_ERR)          err <= 1'b1;
    else if (state == ST_ERR && state_nxt == ST_FETCH) err <= 1'b0;
  end

  // Instruction word captured on the accepted read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            instr <= '0;
    else if (fetch_done) instr <= mem_rdata;
  end

  assign instr_valid = in_issue;
  assign busy        = in_fetch || in_issue;
  assign mem_req     = in_fetch;
  assign mem_addr    = mem_req ? pc_addr : '0;
  assign pc_inc      = handshake && !br_take;
  assign pc_jmp      = handshake && br_take;
  assign pc_addrin   = pc_jmp ? br_target : '0;

`ifdef FETCH_CTRL_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Retired-instruction count, pinned at full scale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           perf_retired <= '0;
    else if (handshake) perf_retired <= sat_inc(perf_retired);
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of fetched words.
module tb_fetch_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TMO_CYC = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              pc_jmp;
  logic [ADDR_W-1:0] pc_addrin;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              br_take;
  logic [ADDR_W-1:0] br_target;
  logic              busy;
  logic              err;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0]       perf_retired;
`endif

  logic              pc_set;
  logic [ADDR_W-1:0] pc_set_val;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pc_addr     (pc),
    .pc_inc      (pc_inc),
    .pc_jmp      (pc_jmp),
    .pc_addrin   (pc_addrin),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_take     (br_take),
    .br_target   (br_target),
    .busy        (busy),
    .err         (err)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_retired (perf_retired)
`endif
  );

  // Program counter owned by the environment, steered by the DUT strobes
  always @(posedge clk) begin
    if (pc_set)      pc <= pc_set_val;
    else if (pc_jmp) pc <= pc_addrin;
    else if (pc_inc) pc <= pc + 1'b1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // From a FETCH cycle: withhold ack for lat cycles, then return data
  task automatic fetch_word(input int lat, input logic [DATA_W-1:0] data);
    for (int i = 0; i < lat; i++) begin
      mem_ack = 1'b0;
      settle();
      chk1("fetch_wait_req", mem_req, 1'b1);
      chk1("fetch_wait_valid", instr_valid, 1'b0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    sb_q.push_back(data);
    settle();
    chk1("fetch_ack_req", mem_req, 1'b1);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // From an ISSUE cycle: stall wait_n cycles, then retire with the given branch
  task automatic issue(input int wait_n, input logic br, input logic [ADDR_W-1:0] tgt);
    logic [DATA_W-1:0] exp;
    chk1("sb_nonempty", sb_q.size() != 0, 1'b1);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    for (int i = 0; i < wait_n; i++) begin
      instr_ready = 1'b0;
      settle();
      chk1("stall_valid", instr_valid, 1'b1);
      chkw("stall_instr", 32'(instr), 32'(exp));
      chk1("stall_pc_inc", pc_inc, 1'b0);
      chk1("stall_pc_jmp", pc_jmp, 1'b0);
      tick();
    end
    instr_ready = 1'b1;
    br_take     = br;
    br_target   = tgt;
    settle();
    chk1("hs_valid", instr_valid, 1'b1);
    chkw("hs_instr", 32'(instr), 32'(exp));
    chk1("hs_pc_inc", pc_inc, !br);
    chk1("hs_pc_jmp", pc_jmp, br);
    chkw("hs_pc_addrin", 32'(pc_addrin), br ? 32'(tgt) : 32'h0);
    tick();
    instr_ready = 1'b0;
    br_take     = 1'b0;
    br_target   = '0;
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    br_take     = 1'b0;
    br_target   = '0;
    pc_set      = 1'b0;
    pc_set_val  = '0;

    // Reset values
    tick();
    settle();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chkw("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chkw("rst_instr", 32'(instr), 32'h0);
    chk1("rst_pc_inc", pc_inc, 1'b0);
    chk1("rst_pc_jmp", pc_jmp, 1'b0);
    chkw("rst_pc_addrin", 32'(pc_addrin), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chkw("rst_perf", 32'(perf_retired), 32'h0);
`endif
    tick();
    rst = 1'b1;

    // Read data outside FETCH is ignored
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    settle();
    chk1("idle_ack_valid", instr_valid, 1'b0);
    chkw("idle_ack_instr", 32'(instr), 32'h0);
    chk1("idle_ack_busy", busy, 1'b0);
    tick();

    // stop suppresses start
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    settle();
    chk1("start_stop_busy", busy, 1'b0);
    chk1("start_stop_req", mem_req, 1'b0);
    tick();

    // Basic fetch from 0x10
    pc_set     = 1'b1;
    pc_set_val = 8'h10;
    start      = 1'b1;
    tick();
    pc_set = 1'b0;
    start  = 1'b0;
    settle();
    chk1("basic_busy", busy, 1'b1);
    chk1("basic_req", mem_req, 1'b1);
    chkw("basic_addr", 32'(mem_addr), 32'h10);
    tick();
    fetch_word(1, 16'hA5A5);
    issue(0, 1'b0, '0);
    settle();
    chk1("basic_next_req", mem_req, 1'b1);
    chkw("basic_next_addr", 32'(mem_addr), 32'h11);

    // Taken branch
    fetch_word(0, 16'h1234);
    issue(0, 1'b1, 8'h40);
    settle();
    chkw("branch_next_addr", 32'(mem_addr), 32'h40);
    chk1("branch_next_pc_jmp", pc_jmp, 1'b0);

    // Backpressure
    fetch_word(2, 16'hBEEF);
    issue(5, 1'b0, '0);
    settle();
    chkw("bp_next_addr", 32'(mem_addr), 32'h41);

    // Timeout after TMO_CYC cycles without ack
    for (int i = 0; i < TMO_CYC; i++) begin
      settle();
      chk1("tmo_wait_req", mem_req, 1'b1);
      chk1("tmo_wait_err", err, 1'b0);
      tick();
    end
    settle();
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_req", mem_req, 1'b0);
    chk1("tmo_busy", busy, 1'b0);
    chkw("tmo_addr", 32'(mem_addr), 32'h0);
    tick();
    tick();
    settle();
    chk1("tmo_err_sticky", err, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    chk1("restart_err", err, 1'b0);
    chk1("restart_req", mem_req, 1'b1);
    chkw("restart_addr", 32'(mem_addr), 32'h41);

    // Stop during FETCH: the word still retires, then IDLE
    stop = 1'b1;
    tick();
    stop = 1'b0;
    fetch_word(1, 16'h5A5A);
    issue(0, 1'b0, '0);
    settle();
    chk1("stop_busy", busy, 1'b0);
    chk1("stop_req", mem_req, 1'b0);
    chkw("stop_pc", 32'(pc), 32'h42);
    tick();
    settle();
    chk1("stop_stays_idle", busy, 1'b0);

    // PC wrap from 0xFF
    pc_set     = 1'b1;
    pc_set_val = 8'hFF;
    start      = 1'b1;
    tick();
    pc_set = 1'b0;
    start  = 1'b0;
    settle();
    chkw("wrap_addr", 32'(mem_addr), 32'hFF);
    fetch_word(0, 16'h0F0F);
    issue(0, 1'b0, '0);
    settle();
    chkw("wrap_next_addr", 32'(mem_addr), 32'h00);

    // Reset in the middle of an ISSUE handshake
    fetch_word(0, 16'h7777);
    instr_ready = 1'b1;
    settle();
    chk1("pre_rst_pc_inc", pc_inc, 1'b1);
    rst = 1'b0;
    settle();
    chk1("mid_rst_pc_inc", pc_inc, 1'b0);
    chk1("mid_rst_pc_jmp", pc_jmp, 1'b0);
    chk1("mid_rst_valid", instr_valid, 1'b0);
    chkw("mid_rst_instr", 32'(instr), 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_req", mem_req, 1'b0);
    chkw("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk1("mid_rst_err", err, 1'b0);
    void'(sb_q.pop_front());
    tick();
    instr_ready = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    chk1("post_rst_busy", busy, 1'b0);
    chkw("post_rst_pc", 32'(pc), 32'h00);
    chkw("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
